// File: rtl/microsequencer.sv
// microsequencer: microstore next-address controller with call/return stack and mfc wait timeout
module microsequencer #(
  parameter int ADDR_W = 7,
  parameter int STACK_DEPTH = 2,
  parameter int TIMEOUT = 16,
  parameter logic [ADDR_W-1:0] FAULT_ADDR = 7'h5C
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [2:0]        ns,
  input  logic [1:0]        cond_sel,
  input  logic              inv,
  input  logic [ADDR_W-1:0] cr_addr,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic [3:0]        cond_in,
  input  logic              mfc,
  output logic [ADDR_W-1:0] index,
  output logic              fault,
  output logic              waiting
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [SPW-1:0]    sp;
  logic [7:0]        wcnt;
  logic [ADDR_W-1:0] inc, top, nxt;
  logic              c, full, empty, wait_to, push, pop, flt;
  assign inc     = index + ADDR_W'(1);
  assign c       = cond_in[cond_sel] ^ inv;
  assign full    = sp == SPW'(STACK_DEPTH);
  assign empty   = sp == '0;
  assign wait_to = wcnt == 8'(TIMEOUT - 1);
  assign push    = ns == 3'b101 && !full;
  assign pop     = ns == 3'b110 && !empty;
  assign waiting = ns == 3'b100 && !mfc && !reset;
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (int'(sp) == i + 1) top = stack[i];
  end
  always_comb begin
    nxt = inc;
    flt = 1'b0;
    case (ns)
      3'b000: nxt = dec_addr;
      3'b001: nxt = inc;
      3'b010: nxt = cr_addr;
      3'b011: nxt = c ? cr_addr : inc;
      3'b100: begin
        nxt = mfc ? inc : wait_to ? FAULT_ADDR : index;
        flt = !mfc && wait_to;
      end
      3'b101: begin
        nxt = full ? FAULT_ADDR : cr_addr;
        flt = full;
      end
      3'b110: begin
        nxt = empty ? FAULT_ADDR : top;
        flt = empty;
      end
      default: nxt = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      index <= '0;
      sp    <= '0;
      wcnt  <= '0;
      fault <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else if (stall) begin
      fault <= 1'b0;
    end else begin
      index <= nxt;
      fault <= flt;
      wcnt  <= (ns == 3'b100 && !mfc && !wait_to) ? wcnt + 8'd1 : 8'd0;
      sp    <= ns == 3'b111 ? '0 : push ? sp + SPW'(1) : pop ? sp - SPW'(1) : sp;
      for (int i = 0; i < STACK_DEPTH; i++)
        if (push && int'(sp) == i) stack[i] <= inc;
    end
  end
endmodule
